peripheral_timer_multi_ahb3: RTL

//  Multi-channel AHB3-Lite timer slave for the MPSoC peripheral BFM subsystem. Per channel:

---
 rtl/peripheral_timer_multi_ahb3.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/peripheral_timer_multi_ahb3.sv
// Multi-channel AHB3-Lite timer: prescaled 32b down-counters, W1C pending bits, per-channel IRQs.
// Define PERIPHERAL_TIMER_CAPTURE_EN to add synchronised capt_i capture inputs.
module peripheral_timer_multi_ahb3 #(
  parameter int HADDR_SIZE     = 32,
  parameter int HDATA_SIZE     = 32,
  parameter int CHANNELS       = 4,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  output logic                  HREADYOUT,
  input  logic                  HREADY,
  output logic                  HRESP,
  output logic                  tint,
  output logic [CHANNELS-1:0]   tint_ch
`ifdef PERIPHERAL_TIMER_CAPTURE_EN
  ,
  input  logic [CHANNELS-1:0]   capt_i
`endif
);

  localparam int CH = CHANNELS;
  localparam int PW = PRESCALE_WIDTH;
  localparam logic [31:0] INFO = {16'h0, 8'(PRESCALE_WIDTH), 8'(CHANNELS)};

  if (HDATA_SIZE != 32) begin : g_bad_data
    $error("HDATA_SIZE must be 32");
  end
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_ch
    $error("CHANNELS must be 1..8");
  end

  logic          dvalid, dwrite;
  logic [9:0]    daddr;
  logic [3:0]    dbe, be;
  logic [31:0]   wd, rdata;
  logic          aphase, wr, wr_pend, wr_ien, wr_gctrl;
  logic          run;
  logic [CH-1:0] pending, ienable, en, oneshot;
  logic [CH-1:0] tick, expire, cap_rise, hw_set, w1c;
  logic [CH-1:0] wr_ctrl, wr_pre, wr_rel, wr_cnt;
  logic [PW-1:0] prescale [CH];
  logic [PW-1:0] pcnt     [CH];
  logic [31:0]   reload   [CH];
  logic [31:0]   count    [CH];
  logic [31:0]   capture  [CH];
  logic          unused;

  assign unused    = ^{HBURST, HPROT, HTRANS[0], HADDR[HADDR_SIZE-1:12]};
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign aphase    = HSEL & HTRANS[1];
  assign wd        = HWDATA[31:0];

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0]  lanes);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (lanes[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  always_comb begin
    case (HSIZE)
      3'b000:  be = 4'b0001 << HADDR[1:0];
      3'b001:  be = HADDR[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (HADDR[11:2])
      10'h000: rdata = 32'(pending);
      10'h001: rdata = 32'(ienable);
      10'h002: rdata = {31'b0, run};
      10'h003: rdata = INFO;
      default: ;
    endcase
    for (int n = 0; n < CH; n++) begin
      if (HADDR[11:2] == 10'(8*n+8))  rdata = {30'b0, oneshot[n], en[n]};
      if (HADDR[11:2] == 10'(8*n+9))  rdata = 32'(prescale[n]);
      if (HADDR[11:2] == 10'(8*n+10)) rdata = reload[n];
      if (HADDR[11:2] == 10'(8*n+11)) rdata = count[n];
      if (HADDR[11:2] == 10'(8*n+12)) rdata = capture[n];
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dvalid <= 1'b0;
      dwrite <= 1'b0;
      daddr  <= '0;
      dbe    <= '0;
      HRDATA <= '0;
    end else if (HREADY) begin
      dvalid <= aphase;
      dwrite <= HWRITE;
      daddr  <= HADDR[11:2];
      dbe    <= be;
      if (aphase & ~HWRITE) HRDATA <= rdata;
    end
  end

  always_comb begin
    wr       = dvalid & dwrite;
    wr_pend  = wr && daddr == 10'h000;
    wr_ien   = wr && daddr == 10'h001;
    wr_gctrl = wr && daddr == 10'h002;
    w1c      = wr_pend ? CH'(merge(32'd0, wd, dbe)) : '0;
    for (int n = 0; n < CH; n++) begin
      wr_ctrl[n] = wr && daddr == 10'(8*n+8);
      wr_pre[n]  = wr && daddr == 10'(8*n+9);
      wr_rel[n]  = wr && daddr == 10'(8*n+10);
      wr_cnt[n]  = wr && daddr == 10'(8*n+11);
      tick[n]    = run & en[n] & (pcnt[n] == prescale[n]);
      expire[n]  = tick[n] & (count[n] == 32'd0);
    end
    hw_set = expire | cap_rise;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      run     <= 1'b0;
      ienable <= '0;
      pending <= '0;
      tint_ch <= '0;
      tint    <= 1'b0;
    end else begin
      if (wr_gctrl && dbe[0]) run <= wd[0];
      if (wr_ien) ienable <= CH'(merge(32'(ienable), wd, dbe));
      // a hardware set in the same cycle as a W1C keeps the bit set
      pending <= (pending & ~w1c) | hw_set;
      tint_ch <= pending & ienable;
      tint    <= |(pending & ienable);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      en      <= '0;
      oneshot <= '0;
      for (int n = 0; n < CH; n++) begin
        prescale[n] <= '0;
        pcnt[n]     <= '0;
        reload[n]   <= '0;
        count[n]    <= '0;
      end
    end else begin
      for (int n = 0; n < CH; n++) begin
        if (run & en[n]) pcnt[n] <= tick[n] ? '0 : pcnt[n] + PW'(1);
        if (tick[n]) begin
          if (count[n] != 32'd0) count[n] <= count[n] - 32'd1;
          else if (!oneshot[n])  count[n] <= reload[n];
          else                   en[n]    <= 1'b0;
        end
        // software writes below override the hardware update above
        if (wr_ctrl[n] && dbe[0]) begin
          en[n]      <= wd[0];
          oneshot[n] <= wd[1];
          if (wd[0] & ~en[n]) begin
            count[n] <= reload[n];
            pcnt[n]  <= '0;
          end
        end
        if (wr_pre[n]) begin
          prescale[n] <= PW'(merge(32'(prescale[n]), wd, dbe));
          pcnt[n]     <= '0;
        end
        if (wr_rel[n]) reload[n] <= merge(reload[n], wd, dbe);
        if (wr_cnt[n]) begin
          count[n] <= merge(count[n], wd, dbe);
          pcnt[n]  <= '0;
        end
      end
    end
  end

`ifdef PERIPHERAL_TIMER_CAPTURE_EN
  logic [CH-1:0] cs1, cs2, cs3;

  assign cap_rise = cs2 & ~cs3;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cs1 <= '0;
      cs2 <= '0;
      cs3 <= '0;
      for (int n = 0; n < CH; n++) capture[n] <= '0;
    end else begin
      cs1 <= capt_i;
      cs2 <= cs1;
      cs3 <= cs2;
      for (int n = 0; n < CH; n++)
        if (cap_rise[n]) capture[n] <= count[n];
    end
  end
`else
  assign cap_rise = '0;

  always_comb begin
    for (int n = 0; n < CH; n++) capture[n] = '0;
  end
`endif

endmodule
